// File: rtl/mips_seq_pkg.sv
// Shared types and helpers for the directed-instruction check sequencer.
package mips_seq_pkg;

    localparam int SEQ_WIDTH = 32;
    localparam logic [SEQ_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    typedef enum logic {
        CHK_ALU = 1'b0,
        CHK_PC  = 1'b1
    } chk_kind_t;

    // 'expect' is a reserved word, hence 'expected'
    typedef struct packed {
        logic [SEQ_WIDTH-1:0] instr;
        logic [SEQ_WIDTH-1:0] expected;
        logic [SEQ_WIDTH-1:0] mask;
        chk_kind_t            kind;
    } seq_entry_t;

    function automatic logic masked_match(input logic [SEQ_WIDTH-1:0] obs,
                                          input logic [SEQ_WIDTH-1:0] expected,
                                          input logic [SEQ_WIDTH-1:0] mask);
        return ((obs ^ expected) & mask) == {SEQ_WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/mips_seq_table.sv
// Entry storage: one synchronous write port, one combinational read port, no reset.
module mips_seq_table
    import mips_seq_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  seq_entry_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output seq_entry_t               rd_data
);

    seq_entry_t mem_r [DEPTH];

    // table write; contents survive reset so a rerun needs no reload
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/mips_check_seq.sv
// Self-checking instruction sequencer: issues table entries to the core and
// compares the observed ALU result or PC against each entry's masked expectation.
module mips_check_seq
    import mips_seq_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int SETTLE       = 1,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [WIDTH-1:0]         load_instr,
    input  logic [WIDTH-1:0]         load_expect,
    input  logic [WIDTH-1:0]         load_mask,
    input  logic                     load_kind,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic [WIDTH-1:0]         obs_alu,
    input  logic [WIDTH-1:0]         obs_pc,
    output logic [WIDTH-1:0]         instr,
    output logic                     instr_valid,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(DEPTH):0]   fail_count,
    output logic [$clog2(DEPTH)-1:0] first_fail
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [3:0]    SETTLE_L  = 4'(SETTLE);
    // with no settle time an entry goes straight to its compare cycle
    localparam seq_state_t    ENTRY_ST  = (SETTLE == 0) ? ST_CHECK : ST_ISSUE;

    seq_state_t    state_r;
    logic [IW-1:0] ptr_r;
    logic [LW-1:0] len_r;
    logic [3:0]    cnt_r;
    seq_entry_t    cur_r;
    logic          instr_valid_r;
    logic          busy_r;
    logic          done_r;
    logic          pass_r;
    logic [LW-1:0] fail_count_r;
    logic [IW-1:0] first_fail_r;

    logic          idle_load_s;
    logic [IW-1:0] rd_idx_s;
    seq_entry_t    tbl_rd_s;
    seq_entry_t    load_entry_s;
    seq_entry_t    fetch_s;
    logic [WIDTH-1:0] obs_s;
    logic          match_s;
    logic          last_s;
    logic [LW-1:0] len_clamp_s;

    mips_seq_table #(.DEPTH(DEPTH)) u_table (
        .clk     (clk),
        .wr_en   (idle_load_s),
        .wr_idx  (load_idx),
        .wr_data (load_entry_s),
        .rd_idx  (rd_idx_s),
        .rd_data (tbl_rd_s)
    );

    // fetch path: index of the entry driven next cycle, with same-cycle load bypass
    always_comb begin
        idle_load_s  = load_en && (state_r == ST_IDLE);
        load_entry_s = '{instr: load_instr, expected: load_expect,
                         mask: load_mask, kind: chk_kind_t'(load_kind)};
        rd_idx_s     = ptr_r;
        if (state_r == ST_IDLE) begin
            rd_idx_s = {IW{1'b0}};
        end else if (state_r == ST_CHECK) begin
            rd_idx_s = ptr_r + IDX_ONE;
        end else begin
            rd_idx_s = ptr_r;
        end
        if (idle_load_s && (load_idx == rd_idx_s)) begin
            fetch_s = load_entry_s;
        end else begin
            fetch_s = tbl_rd_s;
        end
        if (len > DEPTH_L) begin
            len_clamp_s = DEPTH_L;
        end else begin
            len_clamp_s = len;
        end
    end

    // compare path for the entry currently in its CHECK cycle
    always_comb begin
        case (cur_r.kind)
            CHK_ALU: obs_s = obs_alu;
            CHK_PC:  obs_s = obs_pc;
            default: obs_s = obs_alu;
        endcase
        match_s = masked_match(obs_s, cur_r.expected, cur_r.mask);
        last_s  = ({1'b0, ptr_r} == (len_r - LEN_ONE)) || (!match_s && (STOP_ON_FAIL != 0));
    end

    // sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            ptr_r         <= {IW{1'b0}};
            len_r         <= {LW{1'b0}};
            cnt_r         <= 4'd0;
            cur_r         <= '0;
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_count_r  <= {LW{1'b0}};
            first_fail_r  <= {IW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        done_r       <= 1'b0;
                        pass_r       <= 1'b0;
                        fail_count_r <= {LW{1'b0}};
                        first_fail_r <= {IW{1'b0}};
                        ptr_r        <= {IW{1'b0}};
                        cnt_r        <= 4'd0;
                        busy_r       <= 1'b1;
                        if (len == {LW{1'b0}}) begin
                            state_r <= ST_FINISH;
                        end else begin
                            len_r         <= len_clamp_s;
                            cur_r         <= fetch_s;
                            instr_valid_r <= 1'b1;
                            state_r       <= ENTRY_ST;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cnt_r == (SETTLE_L - 4'd1)) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_CHECK;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (!match_s) begin
                        fail_count_r <= fail_count_r + LEN_ONE;
                        if (fail_count_r == {LW{1'b0}}) begin
                            first_fail_r <= ptr_r;
                        end
                    end
                    if (last_s) begin
                        cur_r         <= '0;
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_FINISH;
                    end else begin
                        ptr_r   <= ptr_r + IDX_ONE;
                        cur_r   <= fetch_s;
                        state_r <= ENTRY_ST;
                    end
                end
                ST_FINISH: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    pass_r  <= (fail_count_r == {LW{1'b0}});
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr       = cur_r.instr;
    assign instr_valid = instr_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign fail_count  = fail_count_r;
    assign first_fail  = first_fail_r;

endmodule
